uart: RTL and testbench

Memory-mapped 8N1 UART peripheral at uart_base_addr (0x1000000), sitting on the core's data-memory port beside the CLINT and CLIC. It converts a byte write into a serial frame on the transmit line, deserialises frames from the receive line into a one-byte holding register, and reports status on read. Bit timing comes from clks_per_bit in configure (20 MHz / 115200 gives 172, i.e. 173 clocks per bit).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx.sv | 89 ++++++++
 rtl/uart.sv | 163 ++++++++++++++++
 tb/tb_uart.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART configuration: bit timing, bus window and FSM state encodings.
package configure;

    // 20 MHz / 115200 baud -> 173 clocks per bit, stored as period minus one
    localparam int unsigned clks_per_bit   = 172;
    localparam logic [31:0] uart_base_addr = 32'h0100_0000;
    localparam logic [31:0] uart_top_addr  = 32'h0100_0003;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_DONE  = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: input synchroniser, mid-bit sampling FSM and shift register.
module uart_rx
    import configure::*;
#(
    parameter int unsigned CLKS_PER_BIT = clks_per_bit
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_done,
    output logic       o_ferr
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    logic [1:0]    r_sync;
    rx_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_line;
    logic          w_last;

    assign w_line = r_sync[1];
    assign w_last = (r_cnt == LAST);
    assign o_data = r_shift;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= 2'b11;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            o_done  <= 1'b0;
            o_ferr  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            o_done <= 1'b0;
            o_ferr <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (!w_line) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was only a glitch
                    if (r_cnt == HALF) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= w_line ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_shift <= {w_line, r_shift[7:1]};
                        if (r_bit == 3'd7) r_state <= RX_STOP;
                        else               r_bit   <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= RX_DONE;
                        if (w_line) o_done <= 1'b1;
                        else        o_ferr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DONE: begin
                    if (w_line) r_state <= RX_IDLE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart.sv
// Memory-mapped 8N1 UART: transmit FSM, status/data register and bus handshake.
module uart
    import configure::*;
#(
    parameter int unsigned CLKS_PER_BIT = clks_per_bit
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        uart_valid,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT);

    tx_state_t     r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_data;
    logic          r_tx;

    logic          r_rx_valid;
    logic          r_overrun;
    logic          r_ferr;
    logic [7:0]    r_rx_data;

    logic          r_ready;
    logic [31:0]   r_rdata;

    logic          w_req;
    logic          w_addr_ok;
    logic          w_rd;
    logic          w_rd_clr;
    logic          w_wr_nop;
    logic          w_wr_tx;
    logic          w_tx_start;
    logic          w_tx_busy;
    logic          w_tx_last;
    logic [7:0]    w_rx_byte;
    logic          w_rx_done;
    logic          w_rx_ferr;
    logic          w_unused;

    // r_ready masks the request still held during the ready pulse
    assign w_req      = uart_valid & ~r_ready;
    assign w_addr_ok  = (uart_addr[1:0] == 2'b00);
    assign w_rd       = w_req & ~(|uart_wstrb);
    assign w_rd_clr   = w_rd & w_addr_ok;
    assign w_wr_nop   = w_req & (|uart_wstrb) & ~uart_wstrb[0];
    assign w_wr_tx    = w_req & uart_wstrb[0] & (r_tx_state == TX_IDLE);
    assign w_tx_start = w_wr_tx & w_addr_ok;
    assign w_tx_busy  = (r_tx_state != TX_IDLE);
    assign w_tx_last  = (r_tx_cnt == LAST);
    assign w_unused   = &{1'b0, uart_addr[31:2], uart_wdata[31:8]};

    assign uart_tx    = r_tx;
    assign uart_ready = r_ready;
    assign uart_rdata = r_rdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_data  <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_start) begin
                        r_tx_data  <= uart_wdata[7:0];
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_last) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_last) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) r_tx_state <= TX_STOP;
                        else                  r_tx_bit   <= r_tx_bit + 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (w_tx_last) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_START: r_tx <= 1'b0;
                TX_DATA:  r_tx <= r_tx_data[r_tx_bit];
                default:  r_tx <= 1'b1;
            endcase
        end
    end

    // A completing frame sets its flags even when a read clears them in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_ferr     <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            if (w_rx_done) r_rx_data <= w_rx_byte;
            r_rx_valid <= w_rx_done | (r_rx_valid & ~w_rd_clr);
            r_overrun  <= (w_rx_done & r_rx_valid) | (r_overrun & ~w_rd_clr);
            r_ferr     <= w_rx_ferr | (r_ferr & ~w_rd_clr);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_rd | w_wr_nop | w_wr_tx;
            if (w_rd) begin
                r_rdata <= w_addr_ok ?
                    {20'b0, r_ferr, r_overrun, w_tx_busy, r_rx_valid, r_rx_data} : '0;
            end
        end
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_rx   (uart_rx),
        .o_data (w_rx_byte),
        .o_done (w_rx_done),
        .o_ferr (w_rx_ferr)
    );

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for the UART: bus responses and transmitted frames are checked by monitors.
module tb_uart;

    localparam int unsigned CPB  = 15;
    localparam int unsigned BITC = CPB + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_valid = 1'b0;
    logic [31:0] uart_addr  = '0;
    logic [31:0] uart_wdata = '0;
    logic [3:0]  uart_wstrb = '0;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    uart #(.CLKS_PER_BIT(CPB)) dut (
        .reset      (reset),
        .clock      (clock),
        .uart_valid (uart_valid),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .uart_rx    (uart_rx),
        .uart_tx    (uart_tx)
    );

    typedef struct packed {
        logic        is_read;
        logic [31:0] exp;
        logic [15:0] id;
    } bus_exp_t;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] start;
    } tx_exp_t;

    bus_exp_t bus_q[$];
    tx_exp_t  tx_q[$];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       req_id   = 0;
    bit       tx_mon_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor: every ready pulse retires the oldest outstanding request
    initial begin : mon_bus
        bus_exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && uart_ready === 1'b1) begin
                if (bus_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got ready=1, expected no pending request");
                end else begin
                    e = bus_q.pop_front();
                    if (e.is_read) check($sformatf("read_%0d", e.id), uart_rdata, e.exp);
                end
            end
        end
    end

    // Transmit monitor: samples each frame at mid-bit from the first low cycle
    initial begin : mon_tx
        tx_exp_t    t;
        logic [9:0] f;
        int         s;
        forever begin
            @(negedge clock);
            if (tx_mon_en && !reset && uart_tx === 1'b0) begin
                s = cyc;
                f = '0;
                repeat (BITC / 2 - 1) @(negedge clock);
                f[0] = uart_tx;
                for (int i = 1; i < 10; i++) begin
                    repeat (BITC) @(negedge clock);
                    f[i] = uart_tx;
                end
                if (tx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tx_frame: got frame 0x%0h, expected no frame", f);
                end else begin
                    t = tx_q.pop_front();
                    check($sformatf("tx_frame_%0h", t.data), {22'b0, f}, {22'b0, 1'b1, t.data, 1'b0});
                    check($sformatf("tx_start_cycle_%0h", t.data), s, t.start);
                end
            end
        end
    end

    // Caller is at a negedge; returns the number of cycles until ready was seen
    task automatic bus_req(input logic [3:0] strb, input logic [31:0] wdata,
                           input logic [31:0] exp, input bit push_tx, output int lat);
        bus_exp_t e;
        tx_exp_t  t;
        uart_valid = 1'b1;
        uart_addr  = '0;
        uart_wstrb = strb;
        uart_wdata = wdata;
        e.is_read  = (strb == 4'b0000);
        e.exp      = exp;
        e.id       = 16'(req_id);
        req_id++;
        bus_q.push_back(e);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (uart_ready !== 1'b1 && lat < 1000);
        if (uart_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready after %0d cycles, expected ready", lat);
        end else if (push_tx) begin
            t.data  = wdata[7:0];
            t.start = cyc + 1;
            tx_q.push_back(t);
        end
        uart_valid = 1'b0;
        uart_wstrb = '0;
        @(negedge clock);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stopb);
        uart_rx = 1'b0;
        repeat (BITC) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (BITC) @(negedge clock);
        end
        uart_rx = stopb;
        repeat (BITC) @(negedge clock);
        uart_rx = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    initial begin : stim
        int lat;
        int guard;
        repeat (3) @(negedge clock);
        check("reset_tx", {31'b0, uart_tx}, 32'h1);
        check("reset_ready", {31'b0, uart_ready}, 32'h0);
        check("reset_rdata", uart_rdata, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        bus_req(4'b0001, 32'h55, 32'h0, 1'b1, lat);
        check("wr55_latency", lat, 1);
        repeat (40) @(negedge clock);
        bus_req(4'b0000, 32'h0, 32'h200, 1'b0, lat);
        check("rd_busy_latency", lat, 1);
        repeat (200) @(negedge clock);
        bus_req(4'b0000, 32'h0, 32'h000, 1'b0, lat);

        bus_req(4'b0001, 32'hA5, 32'h0, 1'b1, lat);
        check("wrA5_latency", lat, 1);
        bus_req(4'b0001, 32'h3C, 32'h0, 1'b1, lat);
        check("wr3C_latency_held", lat, 10 * BITC);
        repeat (200) @(negedge clock);

        bus_req(4'b0010, 32'hFF, 32'h0, 1'b0, lat);
        check("wr_nop_latency", lat, 1);
        repeat (200) @(negedge clock);
        bus_req(4'b0000, 32'h0, 32'h000, 1'b0, lat);

        send_rx(8'hC3, 1'b1);
        bus_req(4'b0000, 32'h0, 32'h1C3, 1'b0, lat);
        bus_req(4'b0000, 32'h0, 32'h0C3, 1'b0, lat);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_req(4'b0000, 32'h0, 32'h522, 1'b0, lat);
        bus_req(4'b0000, 32'h0, 32'h022, 1'b0, lat);

        tx_mon_en = 1'b0;
        bus_req(4'b0001, 32'h00, 32'h0, 1'b0, lat);
        uart_rx = 1'b0;
        repeat (40) @(negedge clock);
        check("tx_low_before_reset", {31'b0, uart_tx}, 32'h0);
        #2 reset = 1'b1;
        #1 check("tx_async_reset", {31'b0, uart_tx}, 32'h1);
        repeat (3) @(negedge clock);
        uart_rx = 1'b1;
        reset   = 1'b0;
        repeat (4) @(negedge clock);
        tx_mon_en = 1'b1;
        bus_req(4'b0000, 32'h0, 32'h000, 1'b0, lat);
        bus_req(4'b0001, 32'h0F, 32'h0, 1'b1, lat);
        check("wr0F_latency", lat, 1);
        repeat (200) @(negedge clock);

        send_rx(8'h5A, 1'b0);
        bus_req(4'b0000, 32'h0, 32'h800, 1'b0, lat);
        bus_req(4'b0000, 32'h0, 32'h000, 1'b0, lat);

        uart_rx = 1'b0;
        repeat (5) @(negedge clock);
        uart_rx = 1'b1;
        repeat (30) @(negedge clock);
        bus_req(4'b0000, 32'h0, 32'h000, 1'b0, lat);
        send_rx(8'h3C, 1'b1);
        bus_req(4'b0000, 32'h0, 32'h13C, 1'b0, lat);

        guard = 0;
        while (tx_q.size() != 0 && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        check("tx_queue_drained", tx_q.size(), 0);
        check("bus_queue_drained", bus_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
